mcu_pio_bank: RTL

Parametrised general-purpose I/O bank on the MCU's Avalon-MM peripheral bus: the next generation of the fixed 16-bit output-only PIO. It provides a WIDTH-bit bidirectional port with per-bit direction, atomic set/clear/toggle of the output register, a synchronised input path, and per-bit edge capture with a maskable level interrupt to the Nios II. It sits beside the existing PIOs in the MCU system and replaces them where inputs or interrupts are needed.

---
 rtl/mcu_pio_pkg.sv | 16 +
 rtl/mcu_pio_sync.sv | 31 +++
 rtl/mcu_pio_bank.sv | 129 ++++++++++++
 3 files changed

// File: rtl/mcu_pio_pkg.sv
// Shared constants for the MCU PIO family: register offsets and edge-capture modes.
package mcu_pio_pkg;

  localparam logic [2:0] ADDR_DATA    = 3'd0;
  localparam logic [2:0] ADDR_DIR     = 3'd1;
  localparam logic [2:0] ADDR_IRQMASK = 3'd2;
  localparam logic [2:0] ADDR_EDGECAP = 3'd3;
  localparam logic [2:0] ADDR_OUTSET  = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR  = 3'd5;
  localparam logic [2:0] ADDR_OUTTGL  = 3'd6;

  localparam int unsigned EDGE_RISE = 0;
  localparam int unsigned EDGE_FALL = 1;
  localparam int unsigned EDGE_ANY  = 2;

endpackage

// File: rtl/mcu_pio_sync.sv
// Multi-stage input synchroniser plus one history flop for edge detection.
module mcu_pio_sync #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_i,
  output logic [WIDTH-1:0] in_s_o,
  output logic [WIDTH-1:0] in_d_o
);

  // Index 0 samples the pin; the highest index is the synchronised value.
  logic [SYNC_STAGES-1:0][WIDTH-1:0] chain_q;
  logic [WIDTH-1:0]                  in_d_q;

  // Shift the pins through the chain, then keep one cycle of history.
  always_ff @(posedge clk) begin
    if (reset) begin
      chain_q <= '0;
      in_d_q  <= '0;
    end else begin
      chain_q <= {chain_q[SYNC_STAGES-2:0], in_i};
      in_d_q  <= chain_q[SYNC_STAGES-1];
    end
  end

  assign in_s_o = chain_q[SYNC_STAGES-1];
  assign in_d_o = in_d_q;

endmodule

// File: rtl/mcu_pio_bank.sv
// Avalon-MM GPIO bank: per-bit direction, atomic set/clear/toggle, synchronised inputs,
// sticky edge capture and a maskable level interrupt.
module mcu_pio_bank
  import mcu_pio_pkg::*;
#(
  parameter int unsigned      WIDTH       = 16,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int unsigned      EDGE_TYPE   = EDGE_RISE,
  parameter int unsigned      SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             read,
  input  logic             write,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] oe_port,
  output logic             irq
);

  logic             wr_en, rd_en;
  logic [WIDTH-1:0] wdata;
  logic [31:0]      unused_wdata;
  logic [WIDTH-1:0] in_s, in_d, edge_det;

  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic [WIDTH-1:0] dir_q, dir_d;
  logic [WIDTH-1:0] irqmask_q, irqmask_d;
  logic [WIDTH-1:0] edgecap_q, edgecap_d;
  logic [WIDTH-1:0] rdata_sel;
  logic [31:0]      readdata_q, readdata_d;
  logic             irq_q;

  assign wr_en        = chipselect & write;
  assign rd_en        = chipselect & read;
  assign wdata        = writedata[WIDTH-1:0];
  assign unused_wdata = writedata;

  mcu_pio_sync #(
    .WIDTH      (WIDTH),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .in_i  (in_port),
    .in_s_o(in_s),
    .in_d_o(in_d)
  );

  // Per-bit edge detection selected at elaboration time.
  always_comb begin
    if (EDGE_TYPE == EDGE_FALL) begin
      edge_det = ~in_s & in_d;
    end else if (EDGE_TYPE == EDGE_ANY) begin
      edge_det = in_s ^ in_d;
    end else begin
      edge_det = in_s & ~in_d;
    end
  end

  // Register-file next state; a fresh edge beats a write-1-to-clear on the same bit.
  always_comb begin
    data_out_d = data_out_q;
    dir_d      = dir_q;
    irqmask_d  = irqmask_q;
    edgecap_d  = edgecap_q;
    if (wr_en) begin
      case (address)
        ADDR_DATA:    data_out_d = wdata;
        ADDR_DIR:     dir_d      = wdata;
        ADDR_IRQMASK: irqmask_d  = wdata;
        ADDR_EDGECAP: edgecap_d  = edgecap_q & ~wdata;
        ADDR_OUTSET:  data_out_d = data_out_q | wdata;
        ADDR_OUTCLR:  data_out_d = data_out_q & ~wdata;
        ADDR_OUTTGL:  data_out_d = data_out_q ^ wdata;
        default:      ;
      endcase
    end
    edgecap_d = edgecap_d | edge_det;
  end

  // Read mux works on current register values, so a same-cycle write is not seen.
  always_comb begin
    case (address)
      ADDR_DATA:    rdata_sel = in_s;
      ADDR_DIR:     rdata_sel = dir_q;
      ADDR_IRQMASK: rdata_sel = irqmask_q;
      ADDR_EDGECAP: rdata_sel = edgecap_q;
      ADDR_OUTSET,
      ADDR_OUTCLR,
      ADDR_OUTTGL:  rdata_sel = data_out_q;
      default:      rdata_sel = '0;
    endcase
    readdata_d = readdata_q;
    if (rd_en) begin
      readdata_d             = '0;
      readdata_d[WIDTH-1:0] = rdata_sel;
    end
  end

  // State update; irq is registered from edgecap and mask, one cycle behind edgecap.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out_q <= RESET_VALUE;
      dir_q      <= '0;
      irqmask_q  <= '0;
      edgecap_q  <= '0;
      readdata_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      data_out_q <= data_out_d;
      dir_q      <= dir_d;
      irqmask_q  <= irqmask_d;
      edgecap_q  <= edgecap_d;
      readdata_q <= readdata_d;
      irq_q      <= |(edgecap_q & irqmask_q);
    end
  end

  assign out_port = data_out_q;
  assign oe_port  = dir_q;
  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule
